tick_generator: RTL and testbench

//   Derives 5 Hz and 1 Hz timing ticks from the free-running system clock for the
//   7-segment clock. The 5 Hz tick drives display blink/scan housekeeping. The 1 Hz

---
 rtl/tick_generator_if.sv | 20 ++
 rtl/tick_generator.sv | 75 +++++++
 tb/tb_tick_generator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tick_generator_if.sv
// Tick outputs of tick_generator, bundled for the display/timekeeping consumers.
// Square-wave signals exist only when TICK_GEN_SQUARE_EN is defined.
`timescale 1ns/1ps

interface tick_generator_if;
  logic clk_out_5Hz;
  logic clk_out_1Hz;
`ifdef TICK_GEN_SQUARE_EN
  logic sq_out_5Hz;
  logic sq_out_1Hz;
`endif

`ifdef TICK_GEN_SQUARE_EN
  modport master (output clk_out_5Hz, output clk_out_1Hz, output sq_out_5Hz, output sq_out_1Hz);
  modport slave  (input  clk_out_5Hz, input  clk_out_1Hz, input  sq_out_5Hz, input  sq_out_1Hz);
`else
  modport master (output clk_out_5Hz, output clk_out_1Hz);
  modport slave  (input  clk_out_5Hz, input  clk_out_1Hz);
`endif
endinterface

// File: rtl/tick_generator.sv
// Derives one-cycle 5 Hz and 1 Hz enable pulses from clk_in via a two-stage divider.
// Optional square-wave outputs are enabled by defining TICK_GEN_SQUARE_EN.
`timescale 1ns/1ps

module tick_generator #(
  parameter int unsigned CLK_IN_RATE_HZ = 100_000_000
) (
  input  logic             clk_in,
  input  logic             reset,
  tick_generator_if.master tick_o
);

  localparam int unsigned Div5 = CLK_IN_RATE_HZ / 5;
  localparam int unsigned CntW = $clog2(Div5);
  localparam logic [CntW-1:0] Cnt5Max = CntW'(Div5 - 1);
  localparam logic [2:0] Cnt1Max = 3'd4;

  logic [CntW-1:0] cnt5_q, cnt5_d;
  logic [2:0]      cnt1_q, cnt1_d;
  logic            tick5_q, tick5_d;
  logic            tick1_q, tick1_d;
  logic            cnt5_wrap;

`ifdef TICK_GEN_SQUARE_EN
  localparam logic [CntW-1:0] Cnt5Half = CntW'(Div5 / 2);
  logic sq5_q, sq5_d;
  logic sq1_q, sq1_d;
`endif

  always_comb begin
    cnt5_wrap = (cnt5_q == Cnt5Max);
    cnt5_d    = cnt5_wrap ? '0 : cnt5_q + CntW'(1);
    cnt1_d    = cnt1_q;
    if (cnt5_wrap) begin
      cnt1_d = (cnt1_q == Cnt1Max) ? 3'd0 : cnt1_q + 3'd1;
    end
    // Both ticks are registered from the wrap condition, so they land on the same cycle.
    tick5_d = cnt5_wrap;
    tick1_d = cnt5_wrap && (cnt1_q == Cnt1Max);
`ifdef TICK_GEN_SQUARE_EN
    sq5_d = (cnt5_d < Cnt5Half);
    sq1_d = (cnt1_d < 3'd2);
`endif
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt5_q  <= '0;
      cnt1_q  <= 3'd0;
      tick5_q <= 1'b0;
      tick1_q <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
      sq5_q   <= 1'b0;
      sq1_q   <= 1'b0;
`endif
    end else begin
      cnt5_q  <= cnt5_d;
      cnt1_q  <= cnt1_d;
      tick5_q <= tick5_d;
      tick1_q <= tick1_d;
`ifdef TICK_GEN_SQUARE_EN
      sq5_q   <= sq5_d;
      sq1_q   <= sq1_d;
`endif
    end
  end

  assign tick_o.clk_out_5Hz = tick5_q;
  assign tick_o.clk_out_1Hz = tick1_q;
`ifdef TICK_GEN_SQUARE_EN
  assign tick_o.sq_out_5Hz  = sq5_q;
  assign tick_o.sq_out_1Hz  = sq1_q;
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator at 100 Hz and 103 Hz; expectations come from edge counts since release.
`timescale 1ns/1ps

module tb_tick_generator;

  localparam int unsigned Div5 = 20;

  logic clk;
  logic reset;

  int unsigned compared;
  int unsigned mismatched;
  int unsigned n;  // rising edges sampling reset==1 since the last reset

  tick_generator_if tick_if ();
  tick_generator_if tick103_if ();

  tick_generator #(.CLK_IN_RATE_HZ(100)) dut (
    .clk_in (clk),
    .reset  (reset),
    .tick_o (tick_if)
  );

  tick_generator #(.CLK_IN_RATE_HZ(103)) dut103 (
    .clk_in (clk),
    .reset  (reset),
    .tick_o (tick103_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_cnt(input string tag, input int obs, input int exp);
    compared++;
    assert (obs == exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic e5;
    logic e1;
    e5 = (n > 0) && (n % Div5 == 0);
    e1 = (n > 0) && (n % (5 * Div5) == 0);
    check({tag, "/5Hz"}, tick_if.clk_out_5Hz, e5);
    check({tag, "/1Hz"}, tick_if.clk_out_1Hz, e1);
    check({tag, "/103_5Hz"}, tick103_if.clk_out_5Hz, e5);
    check({tag, "/103_1Hz"}, tick103_if.clk_out_1Hz, e1);
`ifdef TICK_GEN_SQUARE_EN
    check({tag, "/sq5"}, tick_if.sq_out_5Hz, (n > 0) && ((n % Div5) < Div5 / 2));
    check({tag, "/sq1"}, tick_if.sq_out_1Hz, (n > 0) && (((n / Div5) % 5) < 2));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset) n++;
    #1;
    check_all(tag);
  endtask

  initial begin
    int p5;
    int p1;
    int orphan;
    int dbl;
    logic prev5;
    int first5;
    int first1;

    compared   = 0;
    mismatched = 0;
    n          = 0;
    reset      = 1'b0;
    #2;
    check_all("reset_state");
    for (int i = 0; i < 3; i++) step("in_reset");

    @(negedge clk);
    reset = 1'b1;
    n     = 0;
    p5 = 0; p1 = 0; orphan = 0; dbl = 0; prev5 = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      step("run300");
      if (tick_if.clk_out_5Hz) p5++;
      if (tick_if.clk_out_1Hz) p1++;
      if (tick_if.clk_out_1Hz && !tick_if.clk_out_5Hz) orphan++;
      if (tick_if.clk_out_5Hz && prev5) dbl++;
      prev5 = tick_if.clk_out_5Hz;
    end
    check_cnt("pulses_5Hz", p5, 15);
    check_cnt("pulses_1Hz", p1, 3);
    check_cnt("orphan_1Hz", orphan, 0);
    check_cnt("double_5Hz", dbl, 0);

    // Both ticks are high right now; asserting reset must kill them without a clock edge.
    reset = 1'b0;
    n     = 0;
    #1;
    check_all("async_drop");
    for (int i = 0; i < 3; i++) step("held_reset");
    @(negedge clk);
    reset  = 1'b1;
    first5 = 0;
    first1 = 0;
    for (int i = 1; i <= 100; i++) begin
      step("after_rst");
      if (tick_if.clk_out_5Hz && first5 == 0) first5 = i;
      if (tick_if.clk_out_1Hz && first1 == 0) first1 = i;
    end
    check_cnt("first_5Hz_latency", first5, 20);
    check_cnt("first_1Hz_latency", first1, 100);

    // Random run lengths with reset asserted at random points inside a cycle.
    for (int k = 0; k < 8; k++) begin
      int unsigned run_len;
      int unsigned hold;
      int unsigned offs;
      run_len = $urandom_range(1, 250);
      hold    = $urandom_range(1, 4);
      offs    = $urandom_range(1, 7);
      for (int unsigned i = 0; i < run_len; i++) step("rand_run");
      #(offs);
      reset = 1'b0;
      n     = 0;
      #1;
      check_all("rand_async");
      for (int unsigned i = 0; i < hold; i++) step("rand_hold");
      @(negedge clk);
      reset = 1'b1;
    end
    for (int i = 0; i < 120; i++) step("rand_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
